bin2bcd_seq: RTL



---
 rtl/bin2bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {StIdle, StShift} state_t;

    typedef logic [3:0] bcd_nibble_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(int unsigned width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

    function automatic longint unsigned pow10(int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            if (r < 64'd1_000_000_000_000_000) r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  bcd_nibble_t din,
    output bcd_nibble_t dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) dout = din + 4'd3;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking is enabled with the BIN2BCD_BLANK_EN macro.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned CW = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 1..16");
    end
    if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic [4*DIGITS-1:0] work_q, work_d, work_adj;
    logic [4*DIGITS-1:0] bcd_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                bcd_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work_q[4*i +: 4]),
            .dout (work_adj[4*i +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bcd_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = bin;
                    work_d  = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                work_d = {work_adj[4*DIGITS-2:0], sreg_q[WIDTH-1]};
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q - CW'(1);
                // Last iteration: the shifted value is the finished result.
                if (cnt_q == CW'(1)) begin
                    bcd_en  = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (bcd_en) bcd_q <= work_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BlankRst = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_q, blank_d;
    logic              lz;

    // Walk from the most significant digit down; ones digit is never blanked.
    always_comb begin
        blank_d = '0;
        lz      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz         = lz & (work_d[4*i +: 4] == 4'd0);
            blank_d[i] = lz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= BlankRst;
        end else if (bcd_en) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule
